// File: rtl/projection_axi4_burst_mem_if.sv
// AXI4 full-slave bus bundle for the projection burst memory (full-width
// transfers only, so no AxSIZE/AxLOCK/AxCACHE/AxPROT/AxQOS fields).
interface projection_axi4_burst_mem_if #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 12,
    parameter int C_ID_WIDTH   = 4
);
    logic [C_ID_WIDTH-1:0]     AWID;
    logic [C_ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]                AWLEN;
    logic [1:0]                AWBURST;
    logic                      AWVALID;
    logic                      AWREADY;
    logic [C_DATA_WIDTH-1:0]   WDATA;
    logic [C_DATA_WIDTH/8-1:0] WSTRB;
    logic                      WLAST;
    logic                      WVALID;
    logic                      WREADY;
    logic [C_ID_WIDTH-1:0]     BID;
    logic [1:0]                BRESP;
    logic                      BVALID;
    logic                      BREADY;
    logic [C_ID_WIDTH-1:0]     ARID;
    logic [C_ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]                ARLEN;
    logic [1:0]                ARBURST;
    logic                      ARVALID;
    logic                      ARREADY;
    logic [C_ID_WIDTH-1:0]     RID;
    logic [C_DATA_WIDTH-1:0]   RDATA;
    logic [1:0]                RRESP;
    logic                      RLAST;
    logic                      RVALID;
    logic                      RREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWBURST, AWVALID,
        input  WDATA, WSTRB, WLAST, WVALID, BREADY,
        input  ARID, ARADDR, ARLEN, ARBURST, ARVALID, RREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWBURST, AWVALID,
        output WDATA, WSTRB, WLAST, WVALID, BREADY,
        output ARID, ARADDR, ARLEN, ARBURST, ARVALID, RREADY,
        input  AWREADY, WREADY, BID, BRESP, BVALID,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/projection_axi4_burst_mem.sv
// AXI4 burst memory for the projection vertex/matrix buffer: FIXED/INCR/WRAP,
// byte strobes, ID echo, SLVERR on WLAST, range and burst-type faults.
module projection_axi4_burst_mem #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 12,
    parameter int C_ID_WIDTH   = 4,
    parameter int C_MEM_DEPTH  = 256
) (
    input logic ACLK,
    input logic ARESET,
    projection_axi4_burst_mem_if.slave s
);
    localparam int BYTES = C_DATA_WIDTH / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int WAW   = C_ADDR_WIDTH - LB;
    localparam int MW    = $clog2(C_MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [WAW-1:0] waddr_t;
    typedef enum logic [1:0] {MODE_FIXED = 2'b00, MODE_INCR = 2'b01, MODE_WRAP = 2'b10} mode_e;
    typedef enum logic [1:0] {W_IDLE = 2'b00, W_DATA = 2'b01, W_RESP = 2'b10} w_state_e;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    localparam waddr_t       ONE_W   = waddr_t'(1);
    localparam logic [WAW:0] DEPTH_W = (WAW + 1)'(C_MEM_DEPTH);

    // Reserved burst code and WRAP with a non power-of-two length are faults.
    function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
        logic err;
        case (burst)
            2'b00, 2'b01: err = 1'b0;
            2'b10:        err = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
            default:      err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic mode_e burst_mode(input logic [1:0] burst, input logic [7:0] len);
        mode_e m;
        case (burst)
            2'b00:   m = MODE_FIXED;
            2'b10:   m = burst_err(burst, len) ? MODE_INCR : MODE_WRAP;
            default: m = MODE_INCR;
        endcase
        return m;
    endfunction

    function automatic waddr_t next_addr(input waddr_t a, input mode_e m, input logic [7:0] len);
        waddr_t mask;
        waddr_t n;
        mask = waddr_t'(len);
        case (m)
            MODE_FIXED: n = a;
            MODE_WRAP:  n = (a & ~mask) | ((a + ONE_W) & mask);
            default:    n = a + ONE_W;
        endcase
        return n;
    endfunction

    function automatic logic in_range(input waddr_t a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    logic [C_DATA_WIDTH-1:0] mem_r [C_MEM_DEPTH];

    w_state_e               w_state_r;
    waddr_t                 w_addr_r;
    logic [7:0]             w_len_r;
    logic [7:0]             w_cnt_r;
    mode_e                  w_mode_r;
    logic                   w_err_r;
    logic                   awready_r;
    logic                   wready_r;
    logic                   bvalid_r;
    logic [C_ID_WIDTH-1:0]  bid_r;
    logic [1:0]             bresp_r;

    r_state_e               r_state_r;
    waddr_t                 r_addr_r;
    logic [7:0]             r_len_r;
    logic [7:0]             r_cnt_r;
    mode_e                  r_mode_r;
    logic                   r_err_r;
    logic                   arready_r;
    logic                   rvalid_r;
    logic                   rlast_r;
    logic [C_ID_WIDTH-1:0]  rid_r;
    logic [C_DATA_WIDTH-1:0] rdata_r;
    logic [1:0]             rresp_r;

    waddr_t                 aw_waddr_s;
    waddr_t                 ar_waddr_s;
    logic                   w_beat_s;
    logic                   w_last_s;
    logic                   w_ok_s;
    logic                   w_beat_err_s;
    waddr_t                 r_load_addr_s;
    logic                   r_load_err_s;
    logic                   r_load_ok_s;
    logic [C_DATA_WIDTH-1:0] r_load_data_s;
    logic [1:0]             r_load_resp_s;

    assign aw_waddr_s   = waddr_t'(s.AWADDR >> LB);
    assign ar_waddr_s   = waddr_t'(s.ARADDR >> LB);
    assign w_beat_s     = (w_state_r == W_DATA) && s.WVALID && wready_r;
    assign w_last_s     = (w_cnt_r == w_len_r);
    assign w_ok_s       = in_range(w_addr_r);
    assign w_beat_err_s = !w_ok_s || (s.WLAST != w_last_s);

    // Read beat source: the AR request itself in idle, the running burst otherwise.
    always_comb begin
        if (r_state_r == R_IDLE) begin
            r_load_addr_s = ar_waddr_s;
            r_load_err_s  = burst_err(s.ARBURST, s.ARLEN);
        end else begin
            r_load_addr_s = r_addr_r;
            r_load_err_s  = r_err_r;
        end
    end

    assign r_load_ok_s   = in_range(r_load_addr_s);
    assign r_load_data_s = r_load_ok_s ? mem_r[r_load_addr_s[MW-1:0]] : {C_DATA_WIDTH{1'b0}};
    assign r_load_resp_s = (r_load_err_s || !r_load_ok_s) ? RESP_SLVERR : RESP_OKAY;

    // Storage array: strobed byte writes, deliberately not cleared by reset.
    always_ff @(posedge ACLK) begin
        if (w_beat_s && w_ok_s) begin
            for (int b = 0; b < BYTES; b++) begin
                if (s.WSTRB[b]) begin
                    mem_r[w_addr_r[MW-1:0]][b*8 +: 8] <= s.WDATA[b*8 +: 8];
                end
            end
        end
    end

    // Write channel FSM: AW capture, data beats, then held B response.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_r <= W_IDLE;
            w_addr_r  <= '0;
            w_len_r   <= 8'd0;
            w_cnt_r   <= 8'd0;
            w_mode_r  <= MODE_INCR;
            w_err_r   <= 1'b0;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bid_r     <= '0;
            bresp_r   <= RESP_OKAY;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (s.AWVALID && awready_r) begin
                        w_addr_r  <= aw_waddr_s;
                        w_len_r   <= s.AWLEN;
                        w_cnt_r   <= 8'd0;
                        w_mode_r  <= burst_mode(s.AWBURST, s.AWLEN);
                        w_err_r   <= burst_err(s.AWBURST, s.AWLEN);
                        bid_r     <= s.AWID;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b1;
                        w_state_r <= W_DATA;
                    end else begin
                        awready_r <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_beat_s) begin
                        w_addr_r <= next_addr(w_addr_r, w_mode_r, w_len_r);
                        w_cnt_r  <= w_cnt_r + 8'd1;
                        w_err_r  <= w_err_r | w_beat_err_s;
                        // Beat count, not WLAST, ends the burst.
                        if (w_last_s) begin
                            wready_r  <= 1'b0;
                            bvalid_r  <= 1'b1;
                            bresp_r   <= (w_err_r || w_beat_err_s) ? RESP_SLVERR : RESP_OKAY;
                            w_state_r <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s.BREADY) begin
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        w_state_r <= W_IDLE;
                    end
                end
                default: begin
                    awready_r <= 1'b0;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                    w_state_r <= W_IDLE;
                end
            endcase
        end
    end

    // Read channel FSM: a new beat is registered on AR accept and on each R handshake.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state_r <= R_IDLE;
            r_addr_r  <= '0;
            r_len_r   <= 8'd0;
            r_cnt_r   <= 8'd0;
            r_mode_r  <= MODE_INCR;
            r_err_r   <= 1'b0;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rid_r     <= '0;
            rdata_r   <= {C_DATA_WIDTH{1'b0}};
            rresp_r   <= RESP_OKAY;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (s.ARVALID && arready_r) begin
                        r_len_r   <= s.ARLEN;
                        r_cnt_r   <= 8'd0;
                        r_mode_r  <= burst_mode(s.ARBURST, s.ARLEN);
                        r_err_r   <= r_load_err_s;
                        r_addr_r  <= next_addr(ar_waddr_s, burst_mode(s.ARBURST, s.ARLEN), s.ARLEN);
                        rid_r     <= s.ARID;
                        rdata_r   <= r_load_data_s;
                        rresp_r   <= r_load_resp_s;
                        rlast_r   <= (s.ARLEN == 8'd0);
                        rvalid_r  <= 1'b1;
                        arready_r <= 1'b0;
                        r_state_r <= R_DATA;
                    end else begin
                        arready_r <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s.RREADY && rvalid_r) begin
                        if (rlast_r) begin
                            rvalid_r  <= 1'b0;
                            rlast_r   <= 1'b0;
                            arready_r <= 1'b1;
                            r_state_r <= R_IDLE;
                        end else begin
                            rdata_r  <= r_load_data_s;
                            rresp_r  <= r_load_resp_s;
                            rlast_r  <= (r_cnt_r + 8'd1 == r_len_r);
                            r_cnt_r  <= r_cnt_r + 8'd1;
                            r_addr_r <= next_addr(r_addr_r, r_mode_r, r_len_r);
                        end
                    end
                end
                default: begin
                    rvalid_r  <= 1'b0;
                    rlast_r   <= 1'b0;
                    arready_r <= 1'b0;
                    r_state_r <= R_IDLE;
                end
            endcase
        end
    end

    assign s.AWREADY = awready_r;
    assign s.WREADY  = wready_r;
    assign s.BVALID  = bvalid_r;
    assign s.BID     = bid_r;
    assign s.BRESP   = bresp_r;
    assign s.ARREADY = arready_r;
    assign s.RVALID  = rvalid_r;
    assign s.RLAST   = rlast_r;
    assign s.RID     = rid_r;
    assign s.RDATA   = rdata_r;
    assign s.RRESP   = rresp_r;
endmodule
